// File: rtl/tick_pkg.sv
// Shared constants for the tick generator and its decade stages.
package tick_pkg;

  localparam int unsigned DEC_W      = 4;
  localparam int unsigned DEC_MAX    = 9;
  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/decade_stage.sv
// One divide-by-10 stage: a 0..9 counter stepped by adv, zeroed by clr.
module decade_stage
  import tick_pkg::*;
(
  input  logic             clk5,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             adv,
  output logic [DEC_W-1:0] count,
  output logic             carry
);

  // carry marks the terminal count; the next stage ANDs it with this stage's advance
  assign carry = (count == DEC_W'(DEC_MAX));

  always_ff @(posedge clk5 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (adv) begin
      count <= carry ? '0 : count + DEC_W'(1);
    end
  end

endmodule

// File: rtl/tick_generator.sv
// Programmable prescaler followed by N_DEC cascaded decade stages; emits
// one-cycle tick pulses at period_reg * 10^k cycles.
module tick_generator
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W          = 19,
  parameter int unsigned DEFAULT_PERIOD = 500000,
  parameter int unsigned N_DEC          = 2
) (
  input  logic             clk5,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic [N_DEC:0]   tick,
  output logic             load_err
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period_reg;
  logic             load_ok;
  logic             restart;
  logic             at_end;

  // A rejected load behaves as if load were low, so counting continues untouched
  assign load_ok = load & (period_in >= CNT_W'(MIN_PERIOD));
  assign restart = clear | load_ok;
  assign at_end  = (count == (period_reg - CNT_W'(1)));
  assign tick[0] = enable & ~restart & at_end;

  always_ff @(posedge clk5 or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      period_reg <= CNT_W'(DEFAULT_PERIOD);
      load_err   <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
      if (load_ok) begin
        period_reg <= period_in;
      end
      if (restart) begin
        count <= '0;
      end else if (enable) begin
        count <= at_end ? '0 : count + CNT_W'(1);
      end
    end
  end

  for (genvar k = 1; k <= N_DEC; k++) begin : g_dec
    logic [DEC_W-1:0] dec_count_unused;
    logic             dec_carry;

    decade_stage u_stage (
      .clk5    (clk5),
      .reset_n (reset_n),
      .clr     (restart),
      .adv     (tick[k-1]),
      .count   (dec_count_unused),
      .carry   (dec_carry)
    );

    assign tick[k] = tick[k-1] & dec_carry;
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with CNT_W=8, DEFAULT_PERIOD=5, N_DEC=2.
module tb_tick_generator;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned N_DEC = 2;

  logic             clk5;
  logic             reset_n;
  logic             enable;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] period_in;
  logic [N_DEC:0]   tick;
  logic             load_err;

  int checks;
  int errors;

  tick_generator #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (5),
    .N_DEC          (N_DEC)
  ) dut (
    .clk5      (clk5),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .period_in (period_in),
    .tick      (tick),
    .load_err  (load_err)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  // Leaves the bench at the negedge that opens cycle 1 after release
  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    period_in = '0;
    @(negedge clk5);
    @(negedge clk5);
    reset_n = 1'b1;
    enable  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    load      = 1'b0;
    period_in = '0;
    #1;
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick got=%b want=000", tick);
    end
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_load_err got=%b want=0", load_err);
    end
    repeat (3) @(negedge clk5);
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold_tick got=%b want=000", tick);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    do_reset();
    for (int n = 1; n <= 1000; n++) begin
      exp = {(n % 500 == 0), (n % 50 == 0), (n % 5 == 0)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
  endtask

  task automatic test_enable();
    logic [2:0] exp;
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      enable = !(n >= 3 && n <= 12);
      exp    = {2'b00, (n >= 15 && (n - 15) % 5 == 0)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL enable cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
    enable = 1'b1;
  endtask

  task automatic test_load();
    logic [2:0] exp;
    logic       exp_err;
    do_reset();
    for (int n = 1; n <= 26; n++) begin
      load      = (n == 7 || n == 17 || n == 22);
      period_in = (n == 7) ? 8'd3 : ((n == 17) ? 8'd1 : 8'd0);
      exp       = {2'b00, (n == 5 || n == 10 || n == 13 || n == 16 ||
                           n == 19 || n == 22 || n == 25)};
      exp_err   = (n == 18 || n == 23);
      #1;
      checks++;
      if (tick !== exp || load_err !== exp_err) begin
        errors++;
        $display("FAIL load cyc=%0d got tick=%b err=%b want tick=%b err=%b",
                 n, tick, load_err, exp, exp_err);
      end
      @(negedge clk5);
    end
    load = 1'b0;
  endtask

  task automatic test_clear();
    logic [2:0] exp;
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      enable = (n != 4);
      clear  = (n == 4);
      exp    = {2'b00, (n == 9 || n == 14)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL clear cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
    clear  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_clear_load();
    logic [2:0] exp;
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      clear     = (n == 10);
      load      = (n == 10);
      period_in = 8'd4;
      exp       = {2'b00, (n == 5 || n == 14 || n == 18)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL clear_load cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
    clear = 1'b0;
    load  = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    do_reset();
    for (int n = 1; n <= 38; n++) begin
      load      = (n == 38);
      period_in = 8'd1;
      exp       = {2'b00, (n % 5 == 0)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
    load = 1'b0;
    #1;
    checks++;
    if (load_err !== 1'b1 || tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_before got tick=%b err=%b want tick=000 err=1",
               tick, load_err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (load_err !== 1'b0 || tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async got tick=%b err=%b want tick=000 err=0",
               tick, load_err);
    end
    @(negedge clk5);
    @(negedge clk5);
    reset_n = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      exp = {1'b0, (n == 50), (n % 5 == 0)};
      #1;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL reset_mid_post cyc=%0d got=%b want=%b", n, tick, exp);
      end
      @(negedge clk5);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_enable();
    test_load();
    test_clear();
    test_clear_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
